sram_ctrl: RTL and testbench
============================

// Module: sram_ctrl
// PURPOSE
//   Parametrised multi-channel asynchronous-SRAM controller with valid/ready request handshake and wait states.
//   Arbitrates NCH requesters (e.g. data port, instruction fetch) onto one external SRAM.
//   Returns read data and write acknowledges through a per-channel response pulse.
//   Sits between CPU memory stages and the board SRAM pins.
// PARAMETERS
//   DATA_W   32  SRAM / request data width, multiple of 8
//   ADDR_W   18  SRAM word address width
//   NCH      2   number of requester channels, 1..4; index 0 has highest priority
//   RD_WAIT  1   extra cycles ce_n/oe_n held low beyond the first, 0..15
//   WR_WAIT  1   extra cycles ce_n/we_n held low beyond the first, 0..15
// PORTS
//   clk_50MHz  in     1            system clock
//   rst        in     1            synchronous reset, active-high
//   sram_data  inout  DATA_W       SRAM data bus
//   sram_addr  out    ADDR_W       SRAM address, registered
//   sram_ce_n  out    1            chip enable, active-low, registered
//   sram_oe_n  out    1            output enable, active-low, registered
//   sram_we_n  out    1            write enable, active-low, registered
//   req_valid  in     NCH          request present, one bit per channel
//   req_ready  out    NCH          request accepted this cycle; at most one bit high
//   req_op     in     NCH          `RAM_RD / `RAM_WR per channel
//   req_addr   in     NCH*ADDR_W   channel i at [i*ADDR_W +: ADDR_W]
//   req_wdata  in     NCH*DATA_W   channel i at [i*DATA_W +: DATA_W]
//   rsp_valid  out    NCH          one-cycle completion pulse, one-hot, channel of the finished access
//   rsp_rdata  out    DATA_W       read data, valid with rsp_valid for reads; held until next read
//   busy       out    1            high whenever state != IDLE
// BEHAVIOUR
//   States: IDLE, ACCESS, RECOVER. Counter width clog2(16).
//   IDLE:
//     - req_ready is combinational: lowest-index channel with req_valid set.
//     - Handshake: ch i accepted on req_valid[i] & req_ready[i] (cycle 0).
//     - Accept latches addr/op/wdata/channel; next edge sram_addr loaded, ce_n=0, oe_n=0 (rd) or we_n=0 (wr).
//     - Enters ACCESS; cnt = RD_WAIT or WR_WAIT.
//   ACCESS: lasts cnt+1 cycles (cycles 1..N, N = WAIT+1); cnt decrements each cycle.
//     - Read: sram_data sampled into rsp_rdata at the edge ending cycle N.
//       In cycle N+1: ce_n=oe_n=1, rsp_valid[ch]=1, state IDLE; a new request may be accepted in N+1.
//     - Write: sram_data driven with latched wdata cycles 1..N.
//       In cycle N+1 (RECOVER): we_n=ce_n=1, bus still driven (hold), rsp_valid[ch]=1; IDLE in N+2.
//   Bus drive: sram_data is Z except in write ACCESS/RECOVER; never driven while oe_n=0.
//   req_ready = 0 in ACCESS/RECOVER and during rst. Requests not accepted wait; no starvation guarantee.
//   Request inputs are sampled only at accept; later changes are ignored.
//   Latency: read rsp at cycle RD_WAIT+2; write rsp at cycle WR_WAIT+2; throughput 1 access per N+1 (rd) / N+2 (wr).
//   Reset (rst=1 at an edge), also mid-access:
//     - Next cycle: ce_n=oe_n=we_n=1, sram_addr=0, bus Z, rsp_valid=0, rsp_rdata=0, busy=0, state IDLE.
//     - Aborted access produces no response.
//   Simultaneous req_valid on several channels: only the lowest index is ready; others stay pending.
// CONFIGURATION
//   SRAM_BYTE_EN (compiled in with `define SRAM_BYTE_EN):
//     - Adds req_be in NCH*(DATA_W/8), active-high per channel.
//     - Adds sram_be_n out DATA_W/8, registered, active-low.
//     - Write: sram_be_n = ~latched req_be during ACCESS/RECOVER. Read and idle: sram_be_n = 0.
//     - Reset value 0.
//   Without SRAM_BYTE_EN: neither port exists; every write is full-word.
// STRUCTURE
//   - define.v: `RAM_RD/`RAM_WR, state encodings, max wait constant (15).
//   - Sub-module sram_arb: fixed-priority NCH-way arbiter, combinational grant.
//   - Remainder (FSM, counter, pin registers, tristate) is in sram_ctrl.
// TESTING
//   1. rst high 3 cycles mid write -> next cycle ce_n/we_n=1, bus Z, no rsp_valid; busy=0.
//   2. Defaults; ch0 write addr 0x00010 data 0xDEADBEEF -> we_n low cycles 1-2, rsp_valid=01 cycle 3, IDLE cycle 4.
//   3. ch0 read addr 0x00010 (SRAM model) -> oe_n low cycles 1-2, rsp_valid=01 with rsp_rdata=0xDEADBEEF at cycle 3.
//   4. ch0 and ch1 both valid -> ch0 ready first; ch1 accepted in ch0 rsp cycle (read) and gets rsp_valid=10 later.
//   5. RD_WAIT=0, WR_WAIT=3 -> read rsp at cycle 2; write we_n low 4 cycles, rsp at cycle 5.
//   6. SRAM_BYTE_EN, write req_be=4'b0101 data 0x11223344 -> sram_be_n=4'b1010; readback 0xXX22XX44 bytes updated only.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared constants for the SRAM controller: request opcodes, FSM states, wait-counter sizing.
package sram_ctrl_pkg;
  localparam logic RAM_RD   = 1'b0;
  localparam logic RAM_WR   = 1'b1;
  localparam int   MAX_WAIT = 15;
  localparam int   CNT_W    = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RECOVER = 2'd2
  } state_t;
endpackage

// File: rtl/sram_arb.sv
// Fixed-priority arbiter: lowest-index requester wins, grant is purely combinational.
module sram_arb #(
  parameter int NCH = 2
) (
  input  logic [NCH-1:0] req,
  output logic [NCH-1:0] gnt
);
  always_comb begin
    gnt = '0;
    // Scan high to low so the lowest set index is the last one written.
    for (int i = NCH - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt    = '0;
        gnt[i] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/sram_ctrl.sv
// Multi-channel asynchronous SRAM controller with wait states and per-channel response pulses.
// Optional per-byte write enables are compiled in with `define SRAM_BYTE_EN.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 18,
  parameter int NCH     = 2,
  parameter int RD_WAIT = 1,
  parameter int WR_WAIT = 1
) (
  input  logic                   clk_50MHz,
  input  logic                   rst,
  inout  wire  [DATA_W-1:0]      sram_data,
  output logic [ADDR_W-1:0]      sram_addr,
  output logic                   sram_ce_n,
  output logic                   sram_oe_n,
  output logic                   sram_we_n,
  input  logic [NCH-1:0]         req_valid,
  output logic [NCH-1:0]         req_ready,
  input  logic [NCH-1:0]         req_op,
  input  logic [NCH*ADDR_W-1:0]  req_addr,
  input  logic [NCH*DATA_W-1:0]  req_wdata,
`ifdef SRAM_BYTE_EN
  input  logic [NCH*(DATA_W/8)-1:0] req_be,
  output logic [DATA_W/8-1:0]    sram_be_n,
`endif
  output logic [NCH-1:0]         rsp_valid,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   busy
);
  localparam int               BE_W   = DATA_W / 8;
  localparam logic [CNT_W-1:0] RD_CNT = CNT_W'(RD_WAIT);
  localparam logic [CNT_W-1:0] WR_CNT = CNT_W'(WR_WAIT);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [NCH-1:0]    ch_q, ch_d;
  logic [NCH-1:0]    rsp_valid_q, rsp_valid_d;
  logic              op_q, op_d;
  logic              ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
  logic              drv_q, drv_d;
  logic [BE_W-1:0]   be_n_q, be_n_d;

  logic [NCH-1:0]    gnt;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [BE_W-1:0]   sel_be;
  logic              sel_op;

  sram_arb #(.NCH(NCH)) u_arb (.req(req_valid), .gnt(gnt));

  assign req_ready = (state_q == IDLE && !rst) ? gnt : '0;

  always_comb begin
    sel_addr  = '0;
    sel_op    = RAM_RD;
    sel_wdata = '0;
    sel_be    = '1;
    for (int i = 0; i < NCH; i++) begin
      if (gnt[i]) begin
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_op    = req_op[i];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
`ifdef SRAM_BYTE_EN
        sel_be    = req_be[i*BE_W +: BE_W];
`endif
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    ch_d        = ch_q;
    op_d        = op_q;
    ce_n_d      = ce_n_q;
    oe_n_d      = oe_n_q;
    we_n_d      = we_n_q;
    drv_d       = drv_q;
    be_n_d      = be_n_q;
    rsp_valid_d = '0;
    case (state_q)
      IDLE: begin
        if (|req_ready) begin
          addr_d  = sel_addr;
          op_d    = sel_op;
          wdata_d = sel_wdata;
          ch_d    = gnt;
          ce_n_d  = 1'b0;
          state_d = ACCESS;
          if (sel_op == RAM_WR) begin
            we_n_d = 1'b0;
            drv_d  = 1'b1;
            cnt_d  = WR_CNT;
            be_n_d = ~sel_be;
          end else begin
            oe_n_d = 1'b0;
            cnt_d  = RD_CNT;
            be_n_d = '0;
          end
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          ce_n_d      = 1'b1;
          oe_n_d      = 1'b1;
          we_n_d      = 1'b1;
          rsp_valid_d = ch_q;
          if (op_q == RAM_WR) begin
            state_d = RECOVER;
          end else begin
            // Last cycle with oe_n low: the SRAM is driving valid data.
            rdata_d = sram_data;
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RECOVER: begin
        drv_d   = 1'b0;
        be_n_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      ch_q        <= '0;
      op_q        <= RAM_RD;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      drv_q       <= 1'b0;
      be_n_q      <= '0;
      rsp_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      ch_q        <= ch_d;
      op_q        <= op_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      drv_q       <= drv_d;
      be_n_q      <= be_n_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign sram_data = drv_q ? wdata_q : 'z;
  assign sram_addr = addr_q;
  assign sram_ce_n = ce_n_q;
  assign sram_oe_n = oe_n_q;
  assign sram_we_n = we_n_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign busy      = (state_q != IDLE);
`ifdef SRAM_BYTE_EN
  assign sram_be_n = be_n_q;
`else
  logic unused_be;
  assign unused_be = ^{be_n_q, sel_be};
`endif
endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl: a default two-channel instance and a one-channel instance with
// RD_WAIT=0 / WR_WAIT=3, each attached to a behavioural asynchronous SRAM.
`timescale 1ns/1ps
module tb_sram_ctrl;
  import sram_ctrl_pkg::*;
  localparam int AW = 18;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #10 clk = ~clk;
  logic rst, clr;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // ---------------- instance A: defaults, NCH=2
  logic [1:0]    a_valid, a_ready, a_op, a_rsp;
  logic [2*AW-1:0] a_addr;
  logic [2*DW-1:0] a_wdata;
  logic [7:0]    a_be;
  logic [3:0]    a_be_n;
  logic [AW-1:0] a_sa;
  logic          a_ce_n, a_oe_n, a_we_n, a_busy;
  logic [DW-1:0] a_rdata;
  wire  [DW-1:0] a_data;

  sram_ctrl #(.DATA_W(DW), .ADDR_W(AW), .NCH(2), .RD_WAIT(1), .WR_WAIT(1)) dut_a (
    .clk_50MHz(clk), .rst(rst), .sram_data(a_data), .sram_addr(a_sa),
    .sram_ce_n(a_ce_n), .sram_oe_n(a_oe_n), .sram_we_n(a_we_n),
    .req_valid(a_valid), .req_ready(a_ready), .req_op(a_op), .req_addr(a_addr),
    .req_wdata(a_wdata),
`ifdef SRAM_BYTE_EN
    .req_be(a_be), .sram_be_n(a_be_n),
`endif
    .rsp_valid(a_rsp), .rsp_rdata(a_rdata), .busy(a_busy));

  // ---------------- instance B: NCH=1, RD_WAIT=0, WR_WAIT=3
  logic [0:0]    b_valid, b_ready, b_op, b_rsp;
  logic [AW-1:0] b_addr, b_sa;
  logic [DW-1:0] b_wdata, b_rdata;
  logic [3:0]    b_be, b_be_n;
  logic          b_ce_n, b_oe_n, b_we_n, b_busy;
  wire  [DW-1:0] b_data;

  sram_ctrl #(.DATA_W(DW), .ADDR_W(AW), .NCH(1), .RD_WAIT(0), .WR_WAIT(3)) dut_b (
    .clk_50MHz(clk), .rst(rst), .sram_data(b_data), .sram_addr(b_sa),
    .sram_ce_n(b_ce_n), .sram_oe_n(b_oe_n), .sram_we_n(b_we_n),
    .req_valid(b_valid), .req_ready(b_ready), .req_op(b_op), .req_addr(b_addr),
    .req_wdata(b_wdata),
`ifdef SRAM_BYTE_EN
    .req_be(b_be), .sram_be_n(b_be_n),
`endif
    .rsp_valid(b_rsp), .rsp_rdata(b_rdata), .busy(b_busy));

`ifndef SRAM_BYTE_EN
  assign a_be_n = 4'h0;
  assign b_be_n = 4'h0;
`endif

  // ---------------- SRAM models (256 words visible)
  logic [DW-1:0] mem_a [256];
  logic [DW-1:0] mem_b [256];
  assign a_data = (!a_ce_n && !a_oe_n && a_we_n) ? mem_a[a_sa[7:0]] : 'z;
  assign b_data = (!b_ce_n && !b_oe_n && b_we_n) ? mem_b[b_sa[7:0]] : 'z;

  always @(posedge clk) begin
    if (clr) for (int i = 0; i < 256; i++) mem_a[i] <= '0;
    else if (!a_ce_n && !a_we_n)
      for (int k = 0; k < 4; k++) if (!a_be_n[k]) mem_a[a_sa[7:0]][k*8 +: 8] <= a_data[k*8 +: 8];
  end
  always @(posedge clk) begin
    if (clr) for (int j = 0; j < 256; j++) mem_b[j] <= '0;
    else if (!b_ce_n && !b_we_n)
      for (int m = 0; m < 4; m++) if (!b_be_n[m]) mem_b[b_sa[7:0]][m*8 +: 8] <= b_data[m*8 +: 8];
  end

  // ---------------- reference: what memory should hold, from request semantics alone
  logic [DW-1:0] ref_a [256];
  logic [DW-1:0] last_rd;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [3:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int k = 0; k < 4; k++) if (be[k]) r[k*8 +: 8] = nw[k*8 +: 8];
    return r;
  endfunction

  // Issue one request on instance A starting at a negedge; returns at the negedge of its response.
  task automatic xact_a(input int ch, input logic op, input logic [7:0] ad, input logic [DW-1:0] wd,
                        input logic [3:0] be, output int lat, output logic [DW-1:0] rd);
    int n;
    int t0;
    a_valid[ch] = 1'b1;
    a_op[ch] = op;
    a_addr[ch*AW +: AW] = {10'h0, ad};
    a_wdata[ch*DW +: DW] = wd;
    a_be[ch*4 +: 4] = be;
    #1;
    n = 0;
    while (!a_ready[ch] && n < 40) begin @(negedge clk); #1; n++; end
    if (!a_ready[ch]) chk("ready_timeout", 64'(a_ready), 64'(1 << ch));
    t0 = cyc;
    @(negedge clk);
    a_valid[ch] = 1'b0;
    a_op[ch] = 1'($urandom);
    a_addr[ch*AW +: AW] = AW'($urandom);
    a_wdata[ch*DW +: DW] = $urandom;
    a_be[ch*4 +: 4] = 4'($urandom);
    n = 0;
    while (!a_rsp[ch] && n < 40) begin @(negedge clk); n++; end
    lat = cyc - t0;
    rd = a_rdata;
    chk("rsp_onehot", 64'(a_rsp), 64'(1 << ch));
  endtask

  typedef struct {
    int            ch;
    logic          op;
    logic [7:0]    ad;
    logic [DW-1:0] wd;
    logic [DW-1:0] exp_rd;
  } vec_t;
  vec_t tbl[6];

  initial begin
    int lat, n, t0, lowcnt;
    logic [DW-1:0] rd, exp;
    logic [3:0] be;
    int ch;
    logic op;
    logic [7:0] ad;
    logic [DW-1:0] wd;

    rst = 1'b1; clr = 1'b1;
    a_valid = '0; a_op = '0; a_addr = '0; a_wdata = '0; a_be = '1;
    b_valid = '0; b_op = '0; b_addr = '0; b_wdata = '0; b_be = '1;
    for (int i = 0; i < 256; i++) ref_a[i] = '0;
    last_rd = '0;
    repeat (3) @(negedge clk);
    a_valid = 2'b11; #1;
    chk("rst_ready", 64'(a_ready), 64'(0));
    chk("rst_pins", 64'({a_ce_n, a_oe_n, a_we_n}), 64'(3'b111));
    chk("rst_state", 64'({a_busy, a_rsp, a_sa}), 64'(0));
    chk("rst_rdata", 64'(a_rdata), 64'(0));
    chk("rst_be_n", 64'(a_be_n), 64'(0));
    a_valid = '0; clr = 1'b0; rst = 1'b0;
    @(negedge clk);

    // Table-driven transactions through the default instance
    tbl[0] = '{0, RAM_WR, 8'h10, 32'hDEADBEEF, 32'h0};
    tbl[1] = '{0, RAM_RD, 8'h10, 32'h0,        32'hDEADBEEF};
    tbl[2] = '{1, RAM_WR, 8'h20, 32'hCAFEF00D, 32'hDEADBEEF};
    tbl[3] = '{1, RAM_RD, 8'h20, 32'h0,        32'hCAFEF00D};
    tbl[4] = '{0, RAM_RD, 8'h30, 32'h0,        32'h0};
    tbl[5] = '{1, RAM_RD, 8'h10, 32'h0,        32'hDEADBEEF};
    for (int i = 0; i < 6; i++) begin
      xact_a(tbl[i].ch, tbl[i].op, tbl[i].ad, tbl[i].wd, 4'hF, lat, rd);
      chk($sformatf("tbl%0d_lat", i), 64'(lat), 64'(3));
      chk($sformatf("tbl%0d_rd", i), 64'(rd), 64'(tbl[i].exp_rd));
      if (tbl[i].op == RAM_WR) ref_a[tbl[i].ad] = tbl[i].wd;
    end
    last_rd = 32'hDEADBEEF;

    // Pin-level write timing: we_n low cycles 1-2, rsp cycle 3, idle cycle 4
    @(negedge clk);
    a_valid[0] = 1'b1; a_op[0] = RAM_WR; a_addr[AW-1:0] = 18'h00040; a_wdata[DW-1:0] = 32'h5A5AA5A5;
    #1 chk("w_ready", 64'(a_ready), 64'(2'b01));
    @(negedge clk); a_valid[0] = 1'b0; a_wdata[DW-1:0] = 32'h0;
    chk("w_c1_pins", 64'({a_ce_n, a_oe_n, a_we_n, a_busy}), 64'(4'b0101));
    chk("w_c1_addr", 64'(a_sa), 64'(18'h00040));
    chk("w_c1_bus", 64'(a_data), 64'(32'h5A5AA5A5));
    @(negedge clk);
    chk("w_c2_pins", 64'({a_ce_n, a_we_n, a_rsp}), 64'(4'b0000));
    @(negedge clk);
    chk("w_c3_pins", 64'({a_ce_n, a_we_n, a_busy, a_rsp}), 64'(5'b11101));
    chk("w_c3_hold", 64'(a_data), 64'(32'h5A5AA5A5));
    a_valid[1] = 1'b1; a_op[1] = RAM_RD; #1;
    chk("w_c3_noready", 64'(a_ready), 64'(0));
    a_valid[1] = 1'b0;
    @(negedge clk);
    chk("w_c4_idle", 64'({a_busy, a_rsp}), 64'(0));
    ref_a[8'h40] = 32'h5A5AA5A5;

    // Pin-level read timing: oe_n low cycles 1-2, rsp + data at cycle 3
    a_valid[0] = 1'b1; a_op[0] = RAM_RD; a_addr[AW-1:0] = 18'h00040;
    @(negedge clk); a_valid[0] = 1'b0;
    chk("r_c1_pins", 64'({a_ce_n, a_oe_n, a_we_n}), 64'(3'b001));
    @(negedge clk);
    chk("r_c2_pins", 64'({a_ce_n, a_oe_n, a_rsp}), 64'(0));
    @(negedge clk);
    chk("r_c3_pins", 64'({a_ce_n, a_oe_n, a_busy, a_rsp}), 64'(5'b11001));
    chk("r_c3_data", 64'(a_rdata), 64'(32'h5A5AA5A5));
    @(negedge clk);
    chk("r_c4_pulse", 64'(a_rsp), 64'(0));
    chk("r_c4_hold", 64'(a_rdata), 64'(32'h5A5AA5A5));

    // Arbitration: both valid, ch0 first, ch1 accepted in ch0's response cycle
    a_valid = 2'b11; a_op = 2'b00;
    a_addr = {18'h00020, 18'h00010};
    #1 chk("arb_ready0", 64'(a_ready), 64'(2'b01));
    @(negedge clk); a_valid[0] = 1'b0;
    n = 0;
    while (a_rsp != 2'b01 && n < 20) begin @(negedge clk); n++; end
    chk("arb_rsp0", 64'({a_rsp, a_rdata}), 64'({2'b01, 32'hDEADBEEF}));
    chk("arb_ready1", 64'(a_ready), 64'(2'b10));
    t0 = cyc;
    @(negedge clk); a_valid[1] = 1'b0;
    n = 0;
    while (a_rsp == 2'b00 && n < 20) begin @(negedge clk); n++; end
    chk("arb_rsp1", 64'({a_rsp, a_rdata}), 64'({2'b10, 32'hCAFEF00D}));
    chk("arb_lat1", 64'(cyc - t0), 64'(3));
    last_rd = 32'hCAFEF00D;
    @(negedge clk);

    // Reset mid-write aborts the access without a response
    a_valid[0] = 1'b1; a_op[0] = RAM_WR; a_addr[AW-1:0] = 18'h000FF; a_wdata[DW-1:0] = 32'h77777777;
    @(negedge clk); a_valid[0] = 1'b0;
    rst = 1'b1;
    a_valid = 2'b01; a_op[0] = RAM_RD;
    @(negedge clk);
    chk("rstw_pins", 64'({a_ce_n, a_oe_n, a_we_n}), 64'(3'b111));
    chk("rstw_state", 64'({a_busy, a_rsp, a_sa}), 64'(0));
    chk("rstw_rdata", 64'(a_rdata), 64'(0));
    chk("rstw_ready", 64'(a_ready), 64'(0));
    lowcnt = 0;
    repeat (2) begin @(negedge clk); if (a_rsp != 0) lowcnt++; end
    a_valid = '0; rst = 1'b0;
    repeat (4) begin @(negedge clk); if (a_rsp != 0 || a_busy) lowcnt++; end
    chk("rstw_no_rsp", 64'(lowcnt), 64'(0));
    last_rd = '0;

`ifdef SRAM_BYTE_EN
    // Partial write: only enabled bytes change
    xact_a(0, RAM_WR, 8'h50, 32'hAABBCCDD, 4'hF, lat, rd);
    @(negedge clk);
    a_valid[0] = 1'b1; a_op[0] = RAM_WR; a_addr[AW-1:0] = 18'h00050;
    a_wdata[DW-1:0] = 32'h11223344; a_be[3:0] = 4'b0101;
    @(negedge clk); a_valid[0] = 1'b0;
    chk("be_c1", 64'(a_be_n), 64'(4'b1010));
    n = 0;
    while (!a_rsp[0] && n < 20) begin @(negedge clk); n++; end
    chk("be_rsp", 64'(a_be_n), 64'(4'b1010));
    @(negedge clk);
    xact_a(0, RAM_RD, 8'h50, 32'h0, 4'hF, lat, rd);
    chk("be_readback", 64'(rd), 64'(32'hAA22CC44));
    chk("be_idle", 64'(a_be_n), 64'(0));
    ref_a[8'h50] = 32'hAA22CC44;
    last_rd = 32'hAA22CC44;
`endif

    // Randomized traffic against the reference memory
    for (int it = 0; it < 60; it++) begin
      ch = int'($urandom_range(0, 1));
      op = 1'($urandom);
      ad = 8'($urandom_range(0, 239));
      wd = $urandom;
`ifdef SRAM_BYTE_EN
      be = 4'($urandom);
`else
      be = 4'hF;
`endif
      if (op == RAM_WR) begin
        exp = last_rd;
        ref_a[ad] = merge(ref_a[ad], wd, be);
      end else begin
        exp = ref_a[ad];
        last_rd = exp;
      end
      xact_a(ch, op, ad, wd, be, lat, rd);
      chk($sformatf("rnd%0d_lat", it), 64'(lat), 64'(3));
      chk($sformatf("rnd%0d_rd", it), 64'(rd), 64'(exp));
      if (op == RAM_WR) @(negedge clk);
    end

    // Instance B: WR_WAIT=3 -> we_n low 4 cycles, rsp at 5; RD_WAIT=0 -> rsp at 2
    @(negedge clk);
    b_valid = 1'b1; b_op = RAM_WR; b_addr = 18'h00005; b_wdata = 32'h12345678;
    #1 chk("b_ready", 64'(b_ready), 64'(1));
    t0 = cyc; lowcnt = 0;
    @(negedge clk); b_valid = 1'b0;
    n = 0;
    while (!b_rsp[0] && n < 40) begin if (!b_we_n) lowcnt++; @(negedge clk); n++; end
    chk("b_wr_lat", 64'(cyc - t0), 64'(5));
    chk("b_wr_low", 64'(lowcnt), 64'(4));
    @(negedge clk);
    chk("b_wr_idle", 64'(b_busy), 64'(0));
    b_valid = 1'b1; b_op = RAM_RD; b_addr = 18'h00005;
    #1 t0 = cyc;
    @(negedge clk); b_valid = 1'b0;
    chk("b_rd_c1", 64'({b_ce_n, b_oe_n}), 64'(0));
    n = 0;
    while (!b_rsp[0] && n < 40) begin @(negedge clk); n++; end
    chk("b_rd_lat", 64'(cyc - t0), 64'(2));
    chk("b_rd_data", 64'(b_rdata), 64'(32'h12345678));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
